// File: rtl/uart_rx_operand_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_operand_pkg : shared FSM encoding and command constants.     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package uart_rx_operand_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    localparam logic [3:0] CMD_A     = 4'hA;
    localparam logic [3:0] CMD_B     = 4'hB;
    localparam int         DATA_BITS = 8;

    // Upper nibble of a received byte selects the operand register.
    function automatic logic [3:0] cmd_nibble(input logic [DATA_BITS-1:0] b);
        return b[DATA_BITS-1 -: 4];
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_core : 8N1 bit-level receiver (synchronizer, FSM, shifter).  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module uart_rx_core
    import uart_rx_operand_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_busy,
    output logic [DATA_BITS-1:0] frame_byte,
    output logic                 frame_ok
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 sync1_q, sync2_q;
    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_frame_err_q, rx_frame_err_d;
    logic                 rx_busy_q, rx_busy_d;
    logic                 stop_ok, stop_bad;

    // Idle-high reset value keeps a released reset from looking like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= uart_rxd;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            idx_q          <= '0;
            shift_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_frame_err_q <= 1'b0;
            rx_busy_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            shift_q        <= shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rx_frame_err_q <= rx_frame_err_d;
            rx_busy_q      <= rx_busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!sync2_q) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = sync2_q ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = sync2_q;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                // Returning at mid-stop leaves half a bit to catch a following start bit.
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                    stop_ok  = sync2_q;
                    stop_bad = !sync2_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_data_d      = stop_ok ? shift_q : rx_data_q;
        rx_valid_d     = stop_ok;
        rx_frame_err_d = stop_bad;
        rx_busy_d      = (state_d != ST_IDLE);
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_frame_err_q;
    assign rx_busy      = rx_busy_q;
    assign frame_byte   = shift_q;
    assign frame_ok     = stop_ok;

endmodule
`default_nettype wire

// File: rtl/uart_rx_operand.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_operand : UART receiver latching A/B operands from commands. |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module uart_rx_operand
    import uart_rx_operand_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_busy,
    output logic [3:0]           operand_a,
    output logic [3:0]           operand_b,
    output logic                 save_a_pulse,
    output logic                 save_b_pulse
);

    logic [DATA_BITS-1:0] frame_byte;
    logic                 frame_ok;
    logic [3:0]           operand_a_q, operand_a_d;
    logic [3:0]           operand_b_q, operand_b_d;
    logic                 save_a_q, save_a_d;
    logic                 save_b_q, save_b_d;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_core (
        .clk          (clk),
        .reset_n      (reset_n),
        .uart_rxd     (uart_rxd),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy),
        .frame_byte   (frame_byte),
        .frame_ok     (frame_ok)
    );

    // Decoded on the same edge that registers rx_valid so the pulses coincide.
    always_comb begin
        operand_a_d = operand_a_q;
        operand_b_d = operand_b_q;
        save_a_d    = 1'b0;
        save_b_d    = 1'b0;
        if (frame_ok) begin
            if (cmd_nibble(frame_byte) == CMD_A) begin
                operand_a_d = frame_byte[3:0];
                save_a_d    = 1'b1;
            end else if (cmd_nibble(frame_byte) == CMD_B) begin
                operand_b_d = frame_byte[3:0];
                save_b_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            operand_a_q <= '0;
            operand_b_q <= '0;
            save_a_q    <= 1'b0;
            save_b_q    <= 1'b0;
        end else begin
            operand_a_q <= operand_a_d;
            operand_b_q <= operand_b_d;
            save_a_q    <= save_a_d;
            save_b_q    <= save_b_d;
        end
    end

    assign operand_a    = operand_a_q;
    assign operand_b    = operand_b_q;
    assign save_a_pulse = save_a_q;
    assign save_b_pulse = save_b_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_operand.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_rx_operand : randomized bench with a frame-level reference.  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_uart_rx_operand;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       uart_rxd;
    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err, rx_busy;
    logic [3:0] operand_a, operand_b;
    logic       save_a_pulse, save_b_pulse;

    int n_checks = 0;
    int n_errors = 0;

    // Expected frame outcomes, written by the stimulus, consumed by the monitor.
    bit   exp_err  [0:255];
    logic [7:0] exp_data [0:255];
    int   wr_idx = 0;
    int   rd_idx = 0;

    logic [7:0] m_data = 8'h00;
    logic [3:0] m_a = 4'h0;
    logic [3:0] m_b = 4'h0;

    uart_rx_operand #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .uart_rxd     (uart_rxd),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .save_a_pulse (save_a_pulse),
        .save_b_pulse (save_b_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        uart_rxd = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_high);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_high ? 1'b1 : 1'b0);
    endtask

    task automatic expect_frame(input logic [7:0] b, input bit err);
        exp_err[wr_idx]  = err;
        exp_data[wr_idx] = b;
        wr_idx++;
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, rx_data, 8'h00);
        check({tag, "_valid"}, rx_valid, 1'b0);
        check({tag, "_ferr"}, rx_frame_err, 1'b0);
        check({tag, "_busy"}, rx_busy, 1'b0);
        check({tag, "_opa"}, operand_a, 4'h0);
        check({tag, "_opb"}, operand_b, 4'h0);
        check({tag, "_saves"}, {save_a_pulse, save_b_pulse}, 2'b00);
    endtask

    // Monitor: every pulse must match the next expected frame outcome.
    always @(negedge clk) begin
        bit         e_err;
        logic [7:0] e_data;
        bit         e_sa, e_sb;
        if (!reset_n) begin
            m_data = 8'h00;
            m_a    = 4'h0;
            m_b    = 4'h0;
            rd_idx = wr_idx;
        end else if (rx_valid || rx_frame_err) begin
            if (rd_idx == wr_idx) begin
                check("unexpected_event", {rx_valid, rx_frame_err}, 2'b00);
            end else begin
                e_err  = exp_err[rd_idx];
                e_data = exp_data[rd_idx];
                rd_idx++;
                e_sa = 1'b0;
                e_sb = 1'b0;
                check("event_valid", rx_valid, !e_err);
                check("event_ferr", rx_frame_err, e_err);
                if (!e_err) begin
                    m_data = e_data;
                    if (e_data[7:4] == 4'hA) begin m_a = e_data[3:0]; e_sa = 1'b1; end
                    if (e_data[7:4] == 4'hB) begin m_b = e_data[3:0]; e_sb = 1'b1; end
                end
                check("ev_rx_data", rx_data, m_data);
                check("ev_operand_a", operand_a, m_a);
                check("ev_operand_b", operand_b, m_b);
                check("ev_save_a", save_a_pulse, e_sa);
                check("ev_save_b", save_b_pulse, e_sb);
            end
        end else if (save_a_pulse || save_b_pulse) begin
            check("stray_save", {save_a_pulse, save_b_pulse}, 2'b00);
        end
    end

    initial begin
        int  lat;
        bit  found;
        int  busy_cnt;
        logic [7:0] b;
        bit  good;
        int  r;

        uart_rxd = 1'b1;
        reset_n  = 1'b0;
        repeat (5) @(negedge clk);
        check_all_zero("por");
        reset_n = 1'b1;
        repeat (20) @(negedge clk);

        // Single 0xA5 with latency measured from the start-bit falling edge.
        expect_frame(8'hA5, 1'b0);
        lat   = 0;
        found = 1'b0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                for (int i = 1; i <= 120 && !found; i++) begin
                    @(posedge clk);
                    #1;
                    if (rx_valid) begin found = 1'b1; lat = i; end
                end
            end
        join
        check("a5_seen", found, 1'b1);
        check("a5_latency_window", (lat >= 76 && lat <= 80), 1'b1);
        idle_bits(2);
        check("a5_data", rx_data, 8'hA5);
        check("a5_opa", operand_a, 4'h5);

        // Back-to-back 0xB3, 0xC7 with no idle time between frames.
        expect_frame(8'hB3, 1'b0);
        expect_frame(8'hC7, 1'b0);
        send_frame(8'hB3, 1'b1);
        send_frame(8'hC7, 1'b1);
        idle_bits(2);
        check("b2b_data", rx_data, 8'hC7);
        check("b2b_opa", operand_a, 4'h5);
        check("b2b_opb", operand_b, 4'h3);

        // 0x5A with a low stop bit.
        expect_frame(8'h5A, 1'b1);
        send_frame(8'h5A, 1'b0);
        idle_bits(3);
        check("ferr_data", rx_data, 8'hC7);
        check("ferr_opa", operand_a, 4'h5);
        check("ferr_opb", operand_b, 4'h3);

        // Two-clock glitch on an idle line.
        uart_rxd = 1'b0;
        repeat (2) @(negedge clk);
        uart_rxd = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1;
            if (rx_busy) busy_cnt++;
        end
        check("glitch_busy_short", (busy_cnt > 0 && busy_cnt <= 4), 1'b1);
        check("glitch_busy_low", rx_busy, 1'b0);
        @(negedge clk);

        // Reset during bit 4 of 0xAF, released during its high bit 7.
        fork
            send_frame(8'hAF, 1'b1);
            begin
                repeat (5 * CPB) @(negedge clk);
                reset_n = 1'b0;
                repeat (CPB) @(negedge clk);
                check_all_zero("midrst");
                repeat (2 * CPB + 4) @(negedge clk);
                reset_n = 1'b1;
            end
        join
        idle_bits(2);
        expect_frame(8'hAE, 1'b0);
        send_frame(8'hAE, 1'b1);
        idle_bits(2);
        check("rst_ae_data", rx_data, 8'hAE);
        check("rst_ae_opa", operand_a, 4'hE);
        check("rst_ae_opb", operand_b, 4'h0);

        // Randomized frames, biased toward A/B commands, some with a bad stop bit.
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 2);
            b[3:0] = 4'($urandom);
            b[7:4] = (r == 0) ? 4'hA : (r == 1) ? 4'hB : 4'($urandom);
            good = ($urandom_range(0, 99) >= 15);
            expect_frame(b, !good);
            send_frame(b, good);
            idle_bits(good ? $urandom_range(0, 2) : $urandom_range(2, 3));
        end

        idle_bits(4);
        check("all_events_seen", wr_idx - rd_idx, 0);
        check("final_busy", rx_busy, 1'b0);
        check("final_data", rx_data, m_data);
        check("final_opa", operand_a, m_a);
        check("final_opb", operand_b, m_b);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
